// File: rtl/cv32e40px_xif_wb_sequencer.sv
// cv32e40px_xif_wb_sequencer: merges buffered X-interface results into register-file
// write port B, behind core writebacks, with a starvation guard for the X result.
// Ports:
//   clk, rst        : clock, async active-high reset
//   core_*          : core writeback request (priority), core_stall_o back-pressure
//   x_*             : X-interface result handshake, x_done_o retire pulse
//   rf_*            : port B lanes (lane 0 in the low bits)
module cv32e40px_xif_wb_sequencer #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int DUAL_WRITE   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                core_we_i,
    input  logic [ADDR_WIDTH-1:0]               core_waddr_i,
    input  logic [DATA_WIDTH-1:0]               core_wdata_i,
    output logic                                core_stall_o,
    input  logic                                x_valid_i,
    output logic                                x_ready_o,
    input  logic [ADDR_WIDTH-1:0]               x_rd_i,
    input  logic [2*DATA_WIDTH-1:0]             x_data_i,
    input  logic                                x_we_i,
    input  logic                                x_dual_i,
    output logic                                x_done_o,
    output logic [DUAL_WRITE:0]                 rf_we_o,
    output logic [ADDR_WIDTH*(1+DUAL_WRITE)-1:0] rf_waddr_o,
    output logic [DATA_WIDTH*(1+DUAL_WRITE)-1:0] rf_wdata_o
);

    localparam bit LP_DUAL = (DUAL_WRITE != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_rd;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    r_dual;
    logic [7:0]              r_starve;
    logic                    r_stall;
    logic                    r_done_nw;

    logic                    w_busy;
    logic                    w_grant;
    logic                    w_blocked;
    logic                    w_final;
    logic [ADDR_WIDTH-1:0]   w_rd_inc;
    logic                    w_we0;
    logic [ADDR_WIDTH-1:0]   w_addr0;
    logic [DATA_WIDTH-1:0]   w_data0;

    assign w_busy    = (r_state != S_IDLE);
    // A stalled core that still asserts core_we_i is dropped in favour of X.
    assign w_grant   = w_busy && (!core_we_i || r_stall);
    assign w_blocked = w_busy && core_we_i && !r_stall;
    // rd+1 wraps inside the 32-entry bank; the bank select bits are kept.
    assign w_rd_inc  = {r_rd[ADDR_WIDTH-1:5], r_rd[4:0] + 5'd1};

    assign x_ready_o    = (r_state == S_IDLE);
    assign core_stall_o = r_stall;
    assign x_done_o     = w_final || r_done_nw;

    always_comb begin
        w_we0   = core_we_i;
        w_addr0 = core_waddr_i;
        w_data0 = core_wdata_i;
        w_final = 1'b0;
        if (w_grant) begin
            w_we0 = 1'b1;
            if (r_state == S_SECOND) begin
                w_addr0 = w_rd_inc;
                w_data0 = r_data[2*DATA_WIDTH-1:DATA_WIDTH];
                w_final = 1'b1;
            end else begin
                w_addr0 = r_rd;
                w_data0 = r_data[DATA_WIDTH-1:0];
                w_final = !r_dual || LP_DUAL;
            end
        end
    end

    generate
        if (LP_DUAL) begin : g_dual
            logic w_we1;
            assign w_we1      = w_grant && (r_state == S_PEND) && r_dual;
            assign rf_we_o    = {w_we1, w_we0};
            assign rf_waddr_o = w_we1 ? {w_rd_inc, w_addr0}
                                      : {{ADDR_WIDTH{1'b0}}, w_addr0};
            assign rf_wdata_o = w_we1 ? {r_data[2*DATA_WIDTH-1:DATA_WIDTH], w_data0}
                                      : {{DATA_WIDTH{1'b0}}, w_data0};
        end else begin : g_single
            assign rf_we_o    = w_we0;
            assign rf_waddr_o = w_addr0;
            assign rf_wdata_o = w_data0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd      <= '0;
            r_data    <= '0;
            r_dual    <= 1'b0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_done_nw <= 1'b0;
        end else begin
            r_done_nw <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (x_valid_i) begin
                        if (x_we_i) begin
                            r_rd    <= x_rd_i;
                            r_data  <= x_data_i;
                            r_dual  <= x_dual_i;
                            r_state <= S_PEND;
                        end else begin
                            r_done_nw <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (w_grant) begin
                        r_state <= (r_dual && !LP_DUAL) ? S_SECOND : S_IDLE;
                    end
                end
                S_SECOND: begin
                    if (w_grant) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Stall rises after STARVE_LIMIT blocked cycles, drops after the X beat.
            if (w_grant) begin
                r_starve <= '0;
                r_stall  <= 1'b0;
            end else if (w_blocked) begin
                r_starve <= r_starve + 8'd1;
                if (r_starve == 8'(STARVE_LIMIT - 1)) begin
                    r_stall <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40px_xif_wb_sequencer.sv
// tb_cv32e40px_xif_wb_sequencer: directed bench driving a split-write (a_) and a
// dual-write (b_) instance with the same stimulus.
module tb_cv32e40px_xif_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_we;
    logic [5:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        x_valid;
    logic [5:0]  x_rd;
    logic [63:0] x_data;
    logic        x_we;
    logic        x_dual;

    logic        a_stall, a_ready, a_done;
    logic [0:0]  a_we;
    logic [5:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_stall, b_ready, b_done;
    logic [1:0]  b_we;
    logic [11:0] b_waddr;
    logic [63:0] b_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40px_xif_wb_sequencer #(.DUAL_WRITE(0)) dut_a (
        .clk(clk), .rst(rst),
        .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
        .core_stall_o(a_stall),
        .x_valid_i(x_valid), .x_ready_o(a_ready), .x_rd_i(x_rd), .x_data_i(x_data),
        .x_we_i(x_we), .x_dual_i(x_dual), .x_done_o(a_done),
        .rf_we_o(a_we), .rf_waddr_o(a_waddr), .rf_wdata_o(a_wdata)
    );

    cv32e40px_xif_wb_sequencer #(.DUAL_WRITE(1)) dut_b (
        .clk(clk), .rst(rst),
        .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
        .core_stall_o(b_stall),
        .x_valid_i(x_valid), .x_ready_o(b_ready), .x_rd_i(x_rd), .x_data_i(x_data),
        .x_we_i(x_we), .x_dual_i(x_dual), .x_done_o(b_done),
        .rf_we_o(b_we), .rf_waddr_o(b_waddr), .rf_wdata_o(b_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        core_we = 1'b1; core_waddr = 6'd3; core_wdata = 32'h55;
        x_valid = 1'b0; x_rd = '0; x_data = '0; x_we = 1'b1; x_dual = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 1);
        chk("rst_done", a_done, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_rf_we", a_we, 1);
        chk("rst_rf_addr", a_waddr, 3);
        chk("rst_b_we", b_we, 2'b01);
        rst = 1'b0; core_we = 1'b0;

        // single result
        step();
        x_valid = 1'b1; x_rd = 6'd5; x_data = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("s_ready", a_ready, 1);
        step();
        x_valid = 1'b0;
        #1;
        chk("s_we", a_we, 1);
        chk("s_addr", a_waddr, 5);
        chk("s_data", a_wdata, 32'hDEADBEEF);
        chk("s_done", a_done, 1);
        chk("s_busy", a_ready, 0);
        step();
        #1;
        chk("s_ready2", a_ready, 1);
        chk("s_done2", a_done, 0);
        chk("s_idle_we", a_we, 0);

        // split dual vs dual write
        x_valid = 1'b1; x_rd = 6'h2A; x_dual = 1'b1; x_data = 64'h1111_1111_2222_2222;
        step();
        x_valid = 1'b0;
        #1;
        chk("d1_addr", a_waddr, 6'h2A);
        chk("d1_data", a_wdata, 32'h22222222);
        chk("d1_done", a_done, 0);
        chk("dw_we", b_we, 2'b11);
        chk("dw_addr", b_waddr, {6'h2B, 6'h2A});
        chk("dw_data", b_wdata, 64'h1111_1111_2222_2222);
        chk("dw_done", b_done, 1);
        step();
        #1;
        chk("d2_we", a_we, 1);
        chk("d2_addr", a_waddr, 6'h2B);
        chk("d2_data", a_wdata, 32'h11111111);
        chk("d2_done", a_done, 1);
        chk("dw_ready", b_ready, 1);

        // wrap 31 -> 0 in int bank
        step();
        #1;
        chk("w_ready", a_ready, 1);
        x_valid = 1'b1; x_rd = 6'd31; x_data = 64'hAAAA_5555_1234_5678;
        step();
        x_valid = 1'b0;
        #1;
        chk("w_b_we", b_we, 2'b11);
        chk("w_b_addr", b_waddr, {6'd0, 6'd31});
        chk("w_a_addr", a_waddr, 6'd31);
        step();
        #1;
        chk("w_a_addr2", a_waddr, 6'd0);
        chk("w_a_data2", a_wdata, 32'hAAAA5555);
        chk("w_a_done", a_done, 1);

        // wrap 63 -> 32 in FP bank
        step();
        #1;
        x_valid = 1'b1; x_rd = 6'h3F; x_data = 64'hCAFE_0001_F00D_0002;
        step();
        x_valid = 1'b0;
        #1;
        chk("fp_b_addr", b_waddr, {6'h20, 6'h3F});
        step();
        #1;
        chk("fp_a_addr", a_waddr, 6'h20);
        chk("fp_a_done", a_done, 1);

        // accepted result without writeback
        step();
        #1;
        x_valid = 1'b1; x_we = 1'b0; x_dual = 1'b0;
        step();
        x_valid = 1'b0; x_we = 1'b1;
        #1;
        chk("nw_done", a_done, 1);
        chk("nw_we", a_we, 0);
        chk("nw_ready", a_ready, 1);
        step();
        #1;
        chk("nw_done2", a_done, 0);

        // starvation
        x_valid = 1'b1; x_rd = 6'd7; x_data = 64'h77;
        core_we = 1'b1; core_waddr = 6'd9; core_wdata = 32'h99;
        #1;
        chk("st_core_idle", a_waddr, 9);
        step();
        x_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("st_stall0_%0d", i), a_stall, 0);
            chk($sformatf("st_core_%0d", i), a_waddr, 9);
            step();
            #1;
        end
        chk("st_stall1", a_stall, 1);
        chk("st_x_addr", a_waddr, 7);
        chk("st_x_data", a_wdata, 32'h77);
        chk("st_done", a_done, 1);
        step();
        #1;
        chk("st_stall_lo", a_stall, 0);
        chk("st_ready", a_ready, 1);
        chk("st_core_back", a_waddr, 9);
        core_we = 1'b0;

        // reset in SECOND
        step();
        #1;
        x_valid = 1'b1; x_rd = 6'd3; x_dual = 1'b1; x_data = 64'h4444_4444_3333_3333;
        step();
        x_valid = 1'b0; x_dual = 1'b0;
        #1;
        chk("r_first", a_waddr, 3);
        core_we = 1'b1; core_waddr = 6'h11;
        step();
        #1;
        chk("r_second_blk", a_ready, 0);
        chk("r_second_core", a_waddr, 6'h11);
        rst = 1'b1;
        #1;
        chk("r_ready", a_ready, 1);
        chk("r_done", a_done, 0);
        chk("r_core_we", a_we, 1);
        step();
        rst = 1'b0; core_we = 1'b0;
        #1;
        chk("r_no_done", a_done, 0);
        chk("r_no_we", a_we, 0);
        x_valid = 1'b1; x_rd = 6'd4; x_data = 64'h4444;
        step();
        x_valid = 1'b0;
        #1;
        chk("r_next_addr", a_waddr, 4);
        chk("r_next_data", a_wdata, 32'h4444);
        chk("r_next_done", a_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
